// File: rtl/demux_stream_n_if.sv
// Stream bundle for demux_stream_n: one input stream, N_OUT output slots, and status.
// The master modport is the upstream/consumer side; the slave modport is the demux itself.
interface demux_stream_n_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic                   pend_any;
  logic [SEL_W-1:0]       pend_idx;
  logic                   drop_pulse;
  logic [CNT_W-1:0]       drop_count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, pend_any, pend_idx, drop_pulse, drop_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, pend_any, pend_idx, drop_pulse, drop_count
  );
endinterface

// File: rtl/demux_stream_n.sv
// 1-to-N streaming demux with one register slot per channel, pass-through on drain,
// highest-pending-channel status and a saturating out-of-range drop counter.
module demux_stream_n #(
  parameter int WIDTH     = 8,
  parameter int N_OUT     = 4,
  parameter int SEL_W     = 2,
  parameter int ZERO_IDLE = 1,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             reset,
  demux_stream_n_if.slave bus
);

  logic [N_OUT-1:0]       valid_q, valid_d;
  logic [N_OUT*WIDTH-1:0] data_q, data_d;
  logic                   drop_q, drop_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [N_OUT-1:0] sel_hit, drain, free, fill;
  logic             in_range, in_ready, accept;
  logic [SEL_W-1:0] pend_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Slot status and handshake; a select beyond N_OUT matches no slot and is always accepted
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      sel_hit[k] = (bus.in_sel == SEL_W'(k));
    end
    drain    = valid_q & bus.out_ready;
    free     = ~valid_q | drain;
    in_range = |sel_hit;
    in_ready = (|(sel_hit & free)) | ~in_range;
    accept   = bus.in_valid & in_ready;
    fill     = sel_hit & {N_OUT{accept}};
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < N_OUT; k++) begin
      valid_d[k] = fill[k] | (valid_q[k] & ~drain[k]);
      if (fill[k]) begin
        data_d[k*WIDTH +: WIDTH] = bus.in_data;
      end else if (drain[k] && ZERO_IDLE != 0) begin
        data_d[k*WIDTH +: WIDTH] = '0;
      end
    end
    drop_d = accept & ~in_range;
    cnt_d  = drop_d ? sat_inc(cnt_q) : cnt_q;
  end

  // Register stage; reset also discards any beat accepted in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Highest pending index wins: ascending scan, last hit overrides
  always_comb begin
    pend_idx = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (valid_q[k]) pend_idx = SEL_W'(k);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.pend_any   = |valid_q;
  assign bus.pend_idx   = pend_idx;
  assign bus.drop_pulse = drop_q;
  assign bus.drop_count = cnt_q;

endmodule
